// File: rtl/mips_divider_if.sv
// mips_divider_if: handshake and operand/result bundle for the MIPS divider.
//   master : requester side (control unit / bench) drives start, is_signed,
//            dividend, divisor (and abort when DIV_ABORT_EN is defined).
//   slave  : divider side, drives busy, done, quotient, remainder, div_by_zero.
// Optional feature macro: DIV_ABORT_EN (adds the abort request line).
interface mips_divider_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
`ifdef DIV_ABORT_EN
    logic             abort;

    modport master (
        output start, is_signed, dividend, divisor, abort,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, abort,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif
endinterface

// File: rtl/mips_divider.sv
// mips_divider: multi-cycle restoring divider serving MIPS DIV/DIVU.
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   bus (slave) : start/is_signed/dividend/divisor in; busy/done/quotient/
//                 remainder/div_by_zero out (all outputs registered)
// One shift-and-subtract iteration per cycle in RUN (WIDTH cycles), then a
// FIX cycle applies signs and loads the result registers with a done pulse.
// Optional feature macro: DIV_ABORT_EN (abort input returns RUN/FIX to IDLE).
module mips_divider #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    mips_divider_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] rem_q;     // partial remainder (raw dividend on divide-by-zero)
    logic [WIDTH-1:0] quo_q;     // dividend magnitude, shifted out as quotient bits enter
    logic [WIDTH-1:0] dsr_q;     // divisor magnitude
    logic             neg_q;     // quotient must be negated
    logic             rneg_q;    // remainder must be negated
    logic             zero_q;    // divisor was zero
    logic [CNT_W-1:0] cnt_q;

    logic             busy_q, done_q, dbz_q;
    logic [WIDTH-1:0] quotient_q, remainder_q;

    logic             busy_next, done_next;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             abort_hit;

`ifdef DIV_ABORT_EN
    assign abort_hit = bus.abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // Magnitude of an operand: two's-complement absolute value for DIV only.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

    // Trial subtraction on the left-shifted {remainder, dividend} pair.
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             ge;

    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = {1'b0, shifted} - {2'b00, dsr_q};
    // No borrow implies the difference is below the divisor, so bit WIDTH is also 0.
    assign ge      = ~|trial[WIDTH+1:WIDTH];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; abort overrides any advance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = (bus.divisor == '0) ? FIX : RUN;
            RUN:     if (cnt_q == CNT_W'(WIDTH - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort_hit) begin
            state_next = IDLE;
        end
    end

    // Output logic: next values of the registered outputs and the signed fix-up.
    always_comb begin
        busy_next = (state_next == RUN) || (state_next == FIX);
        done_next = (state == FIX) && !abort_hit;
        q_fix     = quo_q;
        r_fix     = rem_q;
        if (zero_q) begin
            q_fix = '1;
        end else begin
            if (neg_q)  q_fix = WIDTH'(-quo_q);
            if (rneg_q) r_fix = WIDTH'(-rem_q);
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            neg_q       <= 1'b0;
            rneg_q      <= 1'b0;
            zero_q      <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            busy_q <= busy_next;
            done_q <= done_next;
            if (done_next) begin
                quotient_q  <= q_fix;
                remainder_q <= r_fix;
                dbz_q       <= zero_q;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt_q  <= '0;
                        dsr_q  <= mag(bus.divisor, bus.is_signed);
                        quo_q  <= mag(bus.dividend, bus.is_signed);
                        neg_q  <= bus.is_signed && (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        rneg_q <= bus.is_signed && bus.dividend[WIDTH-1];
                        zero_q <= (bus.divisor == '0);
                        // Divide-by-zero returns the raw dividend as remainder.
                        rem_q  <= (bus.divisor == '0) ? bus.dividend : '0;
                    end
                end
                RUN: begin
                    rem_q <= ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ge};
                    cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mips_divider.sv
// tb_mips_divider: scoreboard bench for mips_divider (WIDTH=32).
// Expected results come from a 64-bit integer reference model, pushed when
// an operation is issued and popped when done is observed.
module tb_mips_divider;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } res_t;

    typedef struct packed {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_divider_if #(.WIDTH(W)) bus ();

    mips_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference: native 64-bit division truncates toward zero, remainder follows dividend.
    function automatic res_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   m;
        longint sa, sb;
        if (b == '0) begin
            m.q = '1;
            m.r = a;
            m.z = 1'b1;
            return m;
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        m.q = W'(sa / sb);
        m.r = W'(sa % sb);
        m.z = 1'b0;
        return m;
    endfunction

    // Drive a start for one edge and record the expected result; returns #1 after that edge.
    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        exp_q.push_back(model(s, a, b));
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.is_signed = 1'($urandom_range(0, 1));
        bus.dividend  = $urandom;
        bus.divisor   = $urandom;
    endtask

    // Wait up to budget edges for done; lat = edges until done, -1 if none.
    task automatic collect(input int budget, output int lat, output res_t got);
        lat = -1;
        got = '0;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                got = {bus.quotient, bus.remainder, bus.div_by_zero};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== {W'(0), W'(0), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_results: got q=%h r=%h z=%b want 0", bus.quotient, bus.remainder, bus.div_by_zero);
        end
        n_checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int   lat;
        res_t got, e;
        issue(1'b0, 32'd100, 32'd7);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL divu_busy_start: got %b want 1", bus.busy);
        end
        collect(40, lat, got);
        e = exp_q.pop_front();
        n_checks++;
        if (lat != 33) begin
            n_fail++;
            $display("FAIL divu_latency: got %0d want 33", lat);
        end
        n_checks++;
        if (got !== e || e.q !== 32'd14 || e.r !== 32'd2) begin
            n_fail++;
            $display("FAIL divu_100_7: got q=%h r=%h z=%b want q=0000000e r=00000002 z=0", got.q, got.r, got.z);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL divu_busy_end: got %b want 0", bus.busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got %b want 0", bus.done);
        end
    endtask

    task automatic test_ops();
        op_t  ops[9];
        int   lat, want_lat;
        res_t got, e;
        ops[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010};
        ops[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2};          // -7 / 2
        ops[2] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF};  // overflow case
        ops[3] = '{1'b1, 32'd7, 32'hFFFF_FFFE};          // 7 / -2
        ops[4] = '{1'b0, 32'd3, 32'd9};                  // dividend below divisor
        for (int i = 5; i < 9; i++) begin
            ops[i] = '{1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 31)};
        end
        for (int i = 0; i < 9; i++) begin
            want_lat = (ops[i].b == '0) ? 1 : 33;
            issue(ops[i].s, ops[i].a, ops[i].b);
            collect(40, lat, got);
            e = exp_q.pop_front();
            n_checks++;
            if (lat != want_lat || got !== e) begin
                n_fail++;
                $display("FAIL op%0d s=%b %h/%h: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=%0d",
                         i, ops[i].s, ops[i].a, ops[i].b, got.q, got.r, got.z, lat, e.q, e.r, e.z, want_lat);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int   lat;
        res_t got, e;
        issue(1'b0, 32'd5, 32'd0);
        collect(5, lat, got);
        e = exp_q.pop_front();
        n_checks++;
        if (lat != 1 || got !== '{32'hFFFF_FFFF, 32'd5, 1'b1}) begin
            n_fail++;
            $display("FAIL divz_unsigned: got q=%h r=%h z=%b lat=%0d want q=ffffffff r=00000005 z=1 lat=1",
                     got.q, got.r, got.z, lat);
        end
        issue(1'b1, 32'hFFFF_FFF7, 32'd0);
        collect(5, lat, got);
        e = exp_q.pop_front();
        n_checks++;
        if (lat != 1 || got !== e) begin
            n_fail++;
            $display("FAIL divz_signed: got q=%h r=%h z=%b lat=%0d want q=%h r=%h z=%b lat=1",
                     got.q, got.r, got.z, lat, e.q, e.r, e.z);
        end
    endtask

    task automatic test_busy_ignore();
        int   lat;
        res_t got, e;
        issue(1'b0, 32'd1000, 32'd3);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        bus.start    = 1'b1;
        bus.dividend = 32'd77;
        bus.divisor  = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_busy: got %b want 1", bus.busy);
        end
        collect(40, lat, got);
        e = exp_q.pop_front();
        n_checks++;
        if (lat != 22 || got !== e) begin
            n_fail++;
            $display("FAIL ignore_start: got q=%h r=%h lat=%0d want q=%h r=%h lat=22", got.q, got.r, lat, e.q, e.r);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        res_t got, e, first;
        issue(1'b1, 32'hFFFF_FF9C, 32'd7);   // -100 / 7
        collect(40, lat, got);
        first = exp_q.pop_front();
        n_checks++;
        if (lat != 33 || got !== first) begin
            n_fail++;
            $display("FAIL b2b_first: got q=%h r=%h lat=%0d want q=%h r=%h lat=33", got.q, got.r, lat, first.q, first.r);
        end
        // Still inside the done cycle: this start must be accepted.
        issue(1'b0, 32'd50, 32'd6);
        n_checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== first.q || bus.remainder !== first.r) begin
            n_fail++;
            $display("FAIL b2b_hold: got busy=%b done=%b q=%h r=%h want busy=1 done=0 q=%h r=%h",
                     bus.busy, bus.done, bus.quotient, bus.remainder, first.q, first.r);
        end
        collect(40, lat, got);
        e = exp_q.pop_front();
        n_checks++;
        if (lat != 33 || got !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got q=%h r=%h lat=%0d want q=%h r=%h lat=33", got.q, got.r, lat, e.q, e.r);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        res_t got, e;
        issue(1'b0, 32'd12345, 32'd67);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got busy=%b done=%b q=%h r=%h z=%b want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        collect(40, lat, got);
        n_checks++;
        if (lat != -1) begin
            n_fail++;
            $display("FAIL reset_no_done: got done after %0d edges want none", lat);
        end
        issue(1'b0, 32'd9, 32'd3);
        collect(40, lat, got);
        e = exp_q.pop_front();
        n_checks++;
        if (lat != 33 || got !== e) begin
            n_fail++;
            $display("FAIL after_reset: got q=%h r=%h lat=%0d want q=%h r=%h lat=33", got.q, got.r, lat, e.q, e.r);
        end
    endtask

`ifdef DIV_ABORT_EN
    task automatic test_abort();
        int   lat;
        res_t got;
        issue(1'b0, 32'd999, 32'd10);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus.abort = 1'b1;
        @(posedge clk);
        #1;
        bus.abort = 1'b0;
        void'(exp_q.pop_back());
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd3 || bus.remainder !== 32'd0) begin
            n_fail++;
            $display("FAIL abort_state: got busy=%b done=%b q=%h r=%h want busy=0 done=0 q=00000003 r=00000000",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        collect(40, lat, got);
        n_checks++;
        if (lat != -1) begin
            n_fail++;
            $display("FAIL abort_no_done: got done after %0d edges want none", lat);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
`ifdef DIV_ABORT_EN
        bus.abort     = 1'b0;
`endif
        test_reset();
        test_divu_basic();
        test_ops();
        test_div_by_zero();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef DIV_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
